// File: rtl/alu_issue_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_issue_stage: ID/EX register that decodes a MIPS instruction into the |
// | ALU operation/operands plus EX control; optional counters under macro    |
// | ALU_ISSUE_COUNT_EN.                                                      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module alu_issue_stage #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [31:0]  instr,
    input  logic [N-1:0] rs_data,
    input  logic [N-1:0] rt_data,
    input  logic         stall,
    input  logic         flush,
    output logic         out_valid,
    output logic [5:0]   alu_operation,
    output logic [N-1:0] alu_input1,
    output logic [N-1:0] alu_input2,
    output logic [4:0]   dest_reg,
    output logic         reg_write,
    output logic         mem_read,
    output logic         mem_write,
    output logic         branch,
    output logic [N-1:0] store_data,
    output logic         illegal,
    output logic [31:0]  issue_count,
    output logic [31:0]  bubble_count
);

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_ADDIU = 6'b001001;
    localparam logic [5:0] c_OP_ANDI  = 6'b001100;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_XORI  = 6'b001110;
    localparam logic [5:0] c_OP_LUI   = 6'b001111;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;

    localparam logic [5:0] c_FN_SRL = 6'b000010;
    localparam logic [5:0] c_FN_SRA = 6'b000011;
    localparam logic [5:0] c_FN_ADD = 6'b100000;
    localparam logic [5:0] c_FN_SUB = 6'b100010;
    localparam logic [5:0] c_FN_AND = 6'b100100;
    localparam logic [5:0] c_FN_OR  = 6'b100101;
    localparam logic [5:0] c_FN_XOR = 6'b100110;
    localparam logic [5:0] c_FN_NOR = 6'b100111;

    logic [5:0]   w_opcode, w_funct;
    logic [4:0]   w_rt, w_rd, w_shamt;
    logic [15:0]  w_imm;
    logic [N-1:0] w_se, w_ze, w_lui, w_sh;

    assign w_opcode = instr[31:26];
    assign w_rt     = instr[20:16];
    assign w_rd     = instr[15:11];
    assign w_shamt  = instr[10:6];
    assign w_funct  = instr[5:0];
    assign w_imm    = instr[15:0];
    assign w_se     = N'($signed(w_imm));
    assign w_ze     = N'(w_imm);
    assign w_lui    = N'({w_imm, 16'h0000});
    assign w_sh     = N'(w_shamt);

    logic         w_ok, w_ill, w_rw, w_mr, w_mw, w_br;
    logic [5:0]   w_op;
    logic [N-1:0] w_in1, w_in2;
    logic [4:0]   w_dest;

    always_comb begin
        w_ok   = 1'b0;
        w_ill  = 1'b0;
        w_rw   = 1'b0;
        w_mr   = 1'b0;
        w_mw   = 1'b0;
        w_br   = 1'b0;
        w_op   = 6'b000000;
        w_in1  = rs_data;
        w_in2  = '0;
        w_dest = w_rt;
        // An all-zero word is the canonical NOP: a bubble, but not illegal.
        if (in_valid && (instr != 32'h0000_0000)) begin
            w_ok = 1'b1;
            w_rw = 1'b1;
            case (w_opcode)
                c_OP_RTYPE: begin
                    w_op   = w_funct;
                    w_dest = w_rd;
                    case (w_funct)
                        c_FN_ADD, c_FN_SUB, c_FN_AND,
                        c_FN_OR, c_FN_XOR, c_FN_NOR: w_in2 = rt_data;
                        c_FN_SRL, c_FN_SRA: begin
                            w_in1 = rt_data;
                            w_in2 = w_sh;
                        end
                        default: w_ok = 1'b0;
                    endcase
                end
                c_OP_ADDI, c_OP_ADDIU: begin w_op = c_FN_ADD; w_in2 = w_se; end
                c_OP_ANDI: begin w_op = c_FN_AND; w_in2 = w_ze; end
                c_OP_ORI:  begin w_op = c_FN_OR;  w_in2 = w_ze; end
                c_OP_XORI: begin w_op = c_FN_XOR; w_in2 = w_ze; end
                c_OP_LUI: begin
                    w_op  = c_FN_OR;
                    w_in1 = '0;
                    w_in2 = w_lui;
                end
                c_OP_LW: begin w_op = c_FN_ADD; w_in2 = w_se; w_mr = 1'b1; end
                c_OP_SW: begin
                    w_op = c_FN_ADD;
                    w_in2 = w_se;
                    w_mw = 1'b1;
                    w_rw = 1'b0;
                end
                c_OP_BEQ: begin
                    w_op  = c_FN_SUB;
                    w_in2 = rt_data;
                    w_br  = 1'b1;
                    w_rw  = 1'b0;
                end
                default: w_ok = 1'b0;
            endcase
            w_ill = ~w_ok;
        end
    end

    logic         w_load;
    logic         r_valid, r_rw, r_mr, r_mw, r_br, r_ill;
    logic [5:0]   r_op;
    logic [N-1:0] r_in1, r_in2, r_sd;
    logic [4:0]   r_dest;

    assign w_load = ~stall & ~flush;

    always_ff @(posedge clk) begin
        if (reset || flush || (w_load && !w_ok)) begin
            r_valid <= 1'b0;
            r_op    <= 6'b000000;
            r_in1   <= '0;
            r_in2   <= '0;
            r_dest  <= 5'd0;
            r_rw    <= 1'b0;
            r_mr    <= 1'b0;
            r_mw    <= 1'b0;
            r_br    <= 1'b0;
            r_sd    <= '0;
            r_ill   <= (reset || flush) ? 1'b0 : w_ill;
        end else if (stall) begin
            // Hold everything; drop illegal so it stays a one-cycle pulse.
            r_ill <= 1'b0;
        end else begin
            r_valid <= 1'b1;
            r_op    <= w_op;
            r_in1   <= w_in1;
            r_in2   <= w_in2;
            r_dest  <= w_dest;
            r_rw    <= w_rw && (w_dest != 5'd0);
            r_mr    <= w_mr;
            r_mw    <= w_mw;
            r_br    <= w_br;
            r_sd    <= rt_data;
            r_ill   <= 1'b0;
        end
    end

    assign out_valid     = r_valid;
    assign alu_operation = r_op;
    assign alu_input1    = r_in1;
    assign alu_input2    = r_in2;
    assign dest_reg      = r_dest;
    assign reg_write     = r_rw;
    assign mem_read      = r_mr;
    assign mem_write     = r_mw;
    assign branch        = r_br;
    assign store_data    = r_sd;
    assign illegal       = r_ill;

`ifdef ALU_ISSUE_COUNT_EN
    logic [31:0] r_issue_cnt, r_bubble_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_issue_cnt  <= 32'd0;
            r_bubble_cnt <= 32'd0;
        end else if (flush || (w_load && !w_ok)) begin
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end else if (w_load) begin
            r_issue_cnt <= r_issue_cnt + 32'd1;
        end
    end

    assign issue_count  = r_issue_cnt;
    assign bubble_count = r_bubble_cnt;
`else
    assign issue_count  = 32'd0;
    assign bubble_count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX pipeline stage that drives the ALU's operand and operation inputs. It is the producer side of the ALU's 6-bit `operation` interface.
- Decodes a 32-bit MIPS instruction plus register-file read data into the ALU operation code, input1 and input2.
- Registers these values, together with destination and control bits, for the EX stage.
- Supports stall (hold), flush (bubble) and illegal-instruction detection.

Parameters:
- N, 32, datapath width of register data and ALU operands.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  instr/rs_data/rt_data are valid this cycle.
- instr  in  32  instruction word.
- rs_data  in  N  register-file value of rs.
- rt_data  in  N  register-file value of rt.
- stall  in  1  hold every output register unchanged.
- flush  in  1  replace the stage contents with a bubble.
- out_valid  out  1  EX stage holds a real instruction.
- alu_operation  out  6  ALU operation code.
- alu_input1  out  N  ALU first operand.
- alu_input2  out  N  ALU second operand.
- dest_reg  out  5  writeback register number.
- reg_write  out  1  writeback enable.
- mem_read  out  1  load.
- mem_write  out  1  store.
- branch  out  1  BEQ (the EX stage tests the ALU zero output).
- store_data  out  N  rt_data, for stores.
- illegal  out  1  one-cycle pulse: the last accepted instruction was undecodable.
- issue_count  out  32  optional counter (see Optional Feature).
- bubble_count  out  32  optional counter (see Optional Feature).

Behaviour:
- Reset: every output is 0, including alu_operation=6'b000000.
- Update priority: reset > flush > stall > load.
  - Flush wins over stall.
  - Flush writes a bubble: out_valid=0, reg_write=mem_read=mem_write=branch=0, illegal=0. Operand registers are cleared to 0.
  - Stall without flush: all registers hold, and illegal is forced to 0 so it stays a single-cycle pulse.
- Load occurs when in_valid=1 and neither stall nor flush is asserted. Outputs appear 1 cycle after the instruction is presented (latency 1).
- When in_valid=0 and there is no stall or flush, a bubble is loaded.
- Fields: op=instr[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0], imm=[15:0].
- Immediate extension: SE = sign-extended imm; ZE = zero-extended imm.
- R-type (op=0): alu_operation=funct, dest_reg=rd, reg_write=1.
  - ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111: in1=rs_data, in2=rt_data.
  - SRL 000010, SRA 000011: in1=rt_data, in2=ZE(shamt).
- I-type: dest_reg=rt.
  - ADDI 001000 / ADDIU 001001: op 100000, SE, reg_write.
  - ANDI 001100: op 100100, ZE, reg_write.
  - ORI 001101: op 100101, ZE, reg_write.
  - XORI 001110: op 100110, ZE, reg_write.
  - LUI 001111: op 100101, in1=0, in2={imm,16'b0}, reg_write.
  - LW 100011: op 100000, in1=rs_data, SE, mem_read, reg_write.
  - SW 101011: op 100000, SE, mem_write, reg_write=0.
  - BEQ 000100: op 100010, in1=rs_data, in2=rt_data, branch=1, reg_write=0.
- instr==32'h0 (NOP) loads a bubble and is not illegal.
- Any other op/funct, including SLL with nonzero word, loads a bubble and sets illegal=1 for one cycle.
- Writes to register 0: reg_write is forced to 0 when dest_reg==0, but out_valid stays 1.
- store_data=rt_data is loaded for every valid instruction.

Optional Feature:
- Macro: ALU_ISSUE_COUNT_EN.
- When defined:
  - issue_count increments on each valid load (out_valid becomes 1 through a load).
  - bubble_count increments on each bubble load, whether from flush, in_valid=0, NOP or illegal.
  - Neither counter increments on a stall cycle.
  - Both reset to 0 and wrap from 32'hFFFFFFFF to 0.
- When not defined: both ports are tied to 0 and no counter logic is generated.

Test Plan:
- Reset, then ADD $3,$1,$2 with rs_data=5, rt_data=7 -> next cycle: out_valid=1, alu_operation=100000, in1=5, in2=7, dest_reg=3, reg_write=1.
- ADDI $4,$1,-1 (imm 16'hFFFF) -> in2=32'hFFFFFFFF. ORI with the same imm -> in2=32'h0000FFFF, op 100101. LUI imm 16'h1234 -> in2=32'h12340000, in1=0.
- SRA $5,$6,4 with rt_data=32'h80000000 -> op 000011, in1=32'h80000000, in2=4, dest_reg=5.
- Load SW, then stall=1 for 3 cycles with a different instr presented -> outputs hold the SW values (mem_write=1). Then stall=flush=1 -> bubble next cycle.
- instr=32'hFC000000 -> illegal=1 for exactly one cycle, out_valid=0. instr=0 -> illegal=0, out_valid=0.
- With ALU_ISSUE_COUNT_EN: 3 valid loads, 2 bubbles, 1 stall cycle -> issue_count=3, bubble_count=2. Mid-run reset -> both counters 0 and all outputs 0 on the next cycle.
